cva5_mem_axi_arbiter: RTL and testbench
=======================================

Name: cva5_mem_axi_arbiter

Overview:
- Shares one single-beat AXI4 master port between two MEM-protocol requesters (port 0: CVA5 instruction side, port 1: CVA5 data side).
- Sits between the CVA5 core memory ports and the SoC crossbar slave port, replacing the tied-off local-memory paths.
- Round-robin arbitration, one transaction in flight.
- Requests outside the legal window are answered locally with an error and issue no AXI traffic.

Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; STRB_W = DATA_W/8.
- AXI_ID, 0, constant value driven on awid/arid.
- WIN_BASE, 32'h0000_0000, lowest legal address.
- WIN_SIZE, 32'hFFFF_FFFF, legal window size in bytes; legal iff WIN_BASE <= addr <= WIN_BASE+WIN_SIZE-1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous assert, active-low.
- req_i  in  2  per-requester request.
- we_i  in  2  per-requester write enable.
- addr_i  in  2xADDR_W  per-requester address.
- wdata_i  in  2xDATA_W  per-requester write data.
- be_i  in  2xSTRB_W  per-requester byte enables.
- gnt_o  out  2  request accepted (one-hot pulse).
- rvalid_o  out  2  response pulse to the owning requester.
- rdata_o  out  DATA_W  read data, shared by both requesters, qualified by rvalid_o.
- err_o  out  1  error flag, qualified by rvalid_o.
- m_axi_aw{valid,ready,addr,id,len,size,burst}  out/in/out/out/out/out/out  -  AW channel.
- m_axi_w{valid,ready,data,strb,last}  out/in/out/out/out  -  W channel.
- m_axi_b{valid,ready,resp,id}  in/out/in/in  -  B channel.
- m_axi_ar{valid,ready,addr,id,len,size,burst}  out/in/out/out/out/out/out  -  AR channel.
- m_axi_r{valid,ready,data,resp,id,last}  in/out/in/in/in/in  -  R channel.

Behaviour:
- Constant AXI fields: len=0, size=$clog2(STRB_W), burst=INCR, wlast=1, ids=AXI_ID.
- rid, bid and rlast are ignored.
- Reset values: state IDLE, rr_last=1 (port 0 wins the first tie), all *valid/*ready/gnt_o/rvalid_o/err_o = 0, rdata_o = 0.
- States: IDLE, AR, R, AW_W, B, LERR.
- IDLE:
  - If any req_i is set, select a winner. A single request wins outright; when both are set, the port != rr_last wins.
  - Assert gnt_o[winner] combinationally in this same cycle.
  - Register addr/wdata/be/we/owner and set rr_last=winner.
  - Next state: LERR if the address is outside the window; else AW_W if we=1; else AR.
- AR: arvalid=1 with the registered address. On arvalid&arready -> R.
- R: rready=1. On rvalid:
  - register rdata and err=rresp[1].
  - pulse rvalid_o[owner] in the next cycle.
  - -> IDLE.
- AW_W:
  - awvalid and wvalid rise together.
  - Each drops independently after its own handshake; acceptance order is free, including the same cycle.
  - Once both handshakes have completed -> B.
- B: bready=1. On bvalid: err=bresp[1]; pulse rvalid_o[owner] next cycle; rdata_o holds its previous value; -> IDLE.
- LERR: pulse rvalid_o[owner] with err=1 next cycle; no AXI activity; -> IDLE.
- Response timing:
  - rvalid_o is exactly one cycle wide and is asserted in the first cycle of IDLE.
  - A new grant may issue in that same cycle, so the minimum request-to-request spacing is one transaction plus one cycle.
- AXI stability: once a valid is raised, address/data/strb hold until the handshake completes.
- gnt_o is never asserted outside IDLE; requests held meanwhile stay pending with no loss.
- Back-to-back, both requesters held: grants strictly alternate 0,1,0,1...
- Asynchronous reset mid-transaction: the block returns to IDLE immediately and all valids drop. The reset is system-wide, so no completion is owed to the requester.
- Window check: uses ADDR_W+1-bit arithmetic so that WIN_BASE+WIN_SIZE does not wrap.

Test Plan:
- Single read: port 0 reads 0x100; arready after 2 cycles; rdata=0xDEADBEEF, rresp=OKAY.
  - Required: gnt_o=01 in the request cycle.
  - Required: araddr=0x100 held until arready.
  - Required: rvalid_o=01 for 1 cycle with rdata_o=0xDEADBEEF, err_o=0.
- Write with channel skew: port 1 writes 0x55AA to 0x200, be=0011; wready comes 3 cycles before awready; bresp=SLVERR.
  - Required: wvalid drops after its handshake while awvalid stays high.
  - Required: rvalid_o=10 with err_o=1.
- Contention: both ports assert continuously, reads, slave ready every cycle.
  - Required: grants 01,10,01,10; never two simultaneous grants.
- Out-of-window access: WIN_BASE=0x8000_0000, WIN_SIZE=0x1000; port 1 reads 0x8000_1000.
  - Required: no arvalid; rvalid_o=10, err_o=1 two cycles after the grant.
- Boundary and reset:
  - Read of 0x8000_0FFC in the same window goes to AXI.
  - Assert rst_ni low while in R: all outputs return to reset values asynchronously.
  - After release, a new request is granted normally.

Source files
------------

// File: rtl/cva5_mem_axi_arbiter.sv
// Purpose: round-robin arbiter sharing one single-beat AXI4 master between CVA5 MEM port 0 (instr) and port 1 (data).
// Latency: grant in the request cycle; rvalid_o one cycle after the R/B beat, or two cycles after grant for out-of-window errors.
// Backpressure: one transaction in flight; requests wait un-granted outside IDLE; AXI valids and payloads hold until handshake.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   req_i/we_i/addr_i/         per-requester MEM request (index 0 = instruction, 1 = data)
//   wdata_i/be_i
//   gnt_o                      one-hot acceptance pulse, only while idle
//   rvalid_o/rdata_o/err_o     one-cycle response to the owning requester; rdata_o/err_o shared
//   m_axi_*                    single-beat AXI4 master (AW, W, B, AR, R)
module cva5_mem_axi_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ID_W     = 4,
  parameter logic [ID_W-1:0]   AXI_ID   = '0,
  parameter logic [ADDR_W-1:0] WIN_BASE = '0,
  parameter logic [ADDR_W-1:0] WIN_SIZE = '1,
  localparam int unsigned      STRB_W   = DATA_W / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             req_i,
  input  logic [1:0]             we_i,
  input  logic [1:0][ADDR_W-1:0] addr_i,
  input  logic [1:0][DATA_W-1:0] wdata_i,
  input  logic [1:0][STRB_W-1:0] be_i,
  output logic [1:0]             gnt_o,
  output logic [1:0]             rvalid_o,
  output logic [DATA_W-1:0]      rdata_o,
  output logic                   err_o,
  output logic                   m_axi_awvalid,
  input  logic                   m_axi_awready,
  output logic [ADDR_W-1:0]      m_axi_awaddr,
  output logic [ID_W-1:0]        m_axi_awid,
  output logic [7:0]             m_axi_awlen,
  output logic [2:0]             m_axi_awsize,
  output logic [1:0]             m_axi_awburst,
  output logic                   m_axi_wvalid,
  input  logic                   m_axi_wready,
  output logic [DATA_W-1:0]      m_axi_wdata,
  output logic [STRB_W-1:0]      m_axi_wstrb,
  output logic                   m_axi_wlast,
  input  logic                   m_axi_bvalid,
  output logic                   m_axi_bready,
  input  logic [1:0]             m_axi_bresp,
  input  logic [ID_W-1:0]        m_axi_bid,
  output logic                   m_axi_arvalid,
  input  logic                   m_axi_arready,
  output logic [ADDR_W-1:0]      m_axi_araddr,
  output logic [ID_W-1:0]        m_axi_arid,
  output logic [7:0]             m_axi_arlen,
  output logic [2:0]             m_axi_arsize,
  output logic [1:0]             m_axi_arburst,
  input  logic                   m_axi_rvalid,
  output logic                   m_axi_rready,
  input  logic [DATA_W-1:0]      m_axi_rdata,
  input  logic [1:0]             m_axi_rresp,
  input  logic [ID_W-1:0]        m_axi_rid,
  input  logic                   m_axi_rlast
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_LERR} state_t;

  // Request captured at grant; drives the AXI payload for the whole transaction.
  typedef struct packed {
    logic              owner;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] be;
  } txn_t;

  state_t          state;
  txn_t            cur;
  logic            rr_last;
  logic            win;
  logic            in_win;
  logic [ADDR_W:0] win_off;

  // Winner select, grant and window check for the candidate request.
  // The offset is taken one bit wider than the address: its top bit flags
  // addr < WIN_BASE, and comparing the offset against WIN_SIZE avoids ever
  // forming WIN_BASE+WIN_SIZE, which could wrap.
  always_comb begin
    win = req_i[1];
    if (req_i == 2'b11) begin
      win = ~rr_last;
    end
    gnt_o = '0;
    if (state == S_IDLE && |req_i) begin
      gnt_o[win] = 1'b1;
    end
    win_off = {1'b0, addr_i[win]} - {1'b0, WIN_BASE};
    in_win  = !win_off[ADDR_W] && (win_off[ADDR_W-1:0] < WIN_SIZE);
  end

  assign m_axi_awaddr  = cur.addr;
  assign m_axi_awid    = AXI_ID;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'($clog2(STRB_W));
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = cur.wdata;
  assign m_axi_wstrb   = cur.be;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_araddr  = cur.addr;
  assign m_axi_arid    = AXI_ID;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'($clog2(STRB_W));
  assign m_axi_arburst = 2'b01;

  // IDs, rlast and the low response bit carry no information for single-beat, single-ID traffic.
  logic unused_axi;
  assign unused_axi = ^{m_axi_bid, m_axi_rid, m_axi_rlast, m_axi_bresp[0], m_axi_rresp[0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= S_IDLE;
      cur           <= '0;
      rr_last       <= 1'b1;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rvalid_o      <= '0;
      rdata_o       <= '0;
      err_o         <= 1'b0;
    end else begin
      rvalid_o <= '0;
      case (state)
        S_IDLE: begin
          if (|req_i) begin
            cur     <= '{owner: win, addr: addr_i[win], wdata: wdata_i[win], be: be_i[win]};
            rr_last <= win;
            if (!in_win) begin
              state <= S_LERR;
            end else if (we_i[win]) begin
              state         <= S_AW_W;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
            end else begin
              state         <= S_AR;
              m_axi_arvalid <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= S_R;
          end
        end
        S_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready        <= 1'b0;
            rdata_o             <= m_axi_rdata;
            err_o               <= m_axi_rresp[1];
            rvalid_o[cur.owner] <= 1'b1;
            state               <= S_IDLE;
          end
        end
        S_AW_W: begin
          // AW and W complete independently; a channel already done counts as complete.
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
          end
          if (m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
          end
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= S_B;
          end
        end
        S_B: begin
          if (m_axi_bvalid) begin
            m_axi_bready        <= 1'b0;
            err_o               <= m_axi_bresp[1];
            rvalid_o[cur.owner] <= 1'b1;
            state               <= S_IDLE;
          end
        end
        S_LERR: begin
          err_o               <= 1'b1;
          rvalid_o[cur.owner] <= 1'b1;
          state               <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cva5_mem_axi_arbiter.sv
module tb_cva5_mem_axi_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance 0: full window. Instance 1: window 0x8000_0000 .. 0x8000_0FFF.
  logic [1:0]         req [2];
  logic [1:0]         we [2];
  logic [1:0][AW-1:0] addr [2];
  logic [1:0][DW-1:0] wdata [2];
  logic [1:0][SW-1:0] be [2];
  logic [1:0]         gnt [2];
  logic [1:0]         rvo [2];
  logic [DW-1:0]      rdata [2];
  logic               err [2];
  logic               awvalid [2], awready [2], wvalid [2], wready [2], wlast [2];
  logic               bvalid [2], bready [2], arvalid [2], arready [2];
  logic               rvalid [2], rready [2], rlast [2];
  logic [AW-1:0]      awaddr [2], araddr [2];
  logic [IW-1:0]      awid [2], arid [2], bid [2], rid [2];
  logic [7:0]         awlen [2], arlen [2];
  logic [2:0]         awsize [2], arsize [2];
  logic [1:0]         awburst [2], arburst [2], bresp [2], rresp [2];
  logic [DW-1:0]      wd [2], rd [2];
  logic [SW-1:0]      wstrb [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cva5_mem_axi_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .AXI_ID(4'h0),
      .WIN_BASE(g == 0 ? 32'h0000_0000 : 32'h8000_0000),
      .WIN_SIZE(g == 0 ? 32'hFFFF_FFFF : 32'h0000_1000)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_i(req[g]), .we_i(we[g]), .addr_i(addr[g]), .wdata_i(wdata[g]), .be_i(be[g]),
      .gnt_o(gnt[g]), .rvalid_o(rvo[g]), .rdata_o(rdata[g]), .err_o(err[g]),
      .m_axi_awvalid(awvalid[g]), .m_axi_awready(awready[g]), .m_axi_awaddr(awaddr[g]),
      .m_axi_awid(awid[g]), .m_axi_awlen(awlen[g]), .m_axi_awsize(awsize[g]), .m_axi_awburst(awburst[g]),
      .m_axi_wvalid(wvalid[g]), .m_axi_wready(wready[g]), .m_axi_wdata(wd[g]),
      .m_axi_wstrb(wstrb[g]), .m_axi_wlast(wlast[g]),
      .m_axi_bvalid(bvalid[g]), .m_axi_bready(bready[g]), .m_axi_bresp(bresp[g]), .m_axi_bid(bid[g]),
      .m_axi_arvalid(arvalid[g]), .m_axi_arready(arready[g]), .m_axi_araddr(araddr[g]),
      .m_axi_arid(arid[g]), .m_axi_arlen(arlen[g]), .m_axi_arsize(arsize[g]), .m_axi_arburst(arburst[g]),
      .m_axi_rvalid(rvalid[g]), .m_axi_rready(rready[g]), .m_axi_rdata(rd[g]),
      .m_axi_rresp(rresp[g]), .m_axi_rid(rid[g]), .m_axi_rlast(rlast[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  int          last_win [2];
  bit          resp_due [2];
  int          resp_own [2];
  logic        resp_err [2];
  bit          resp_data [2];
  logic [31:0] exp_rdata [2];
  logic [1:0]  obs_gnt;
  logic        c_we;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;

  function automatic bit legal(input int u, input logic [31:0] a);
    longint base = (u == 0) ? 64'h0 : 64'h8000_0000;
    longint size = (u == 0) ? 64'hFFFF_FFFF : 64'h1000;
    longint aa   = longint'(a);
    return (aa >= base) && (aa <= base + size - 1);
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      last_win[u]  = 1;
      resp_due[u]  = 0;
      exp_rdata[u] = '0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic slave_idle(input int u);
    awready[u] = 0; wready[u] = 0; bvalid[u] = 0; bresp[u] = 0; bid[u] = 4'h3;
    arready[u] = 0; rvalid[u] = 0; rd[u] = '0; rresp[u] = 0; rid[u] = 4'h5; rlast[u] = 1;
  endtask

  task automatic check_reset_outputs(input int u);
    check("rst_gnt", 64'(gnt[u]), 64'(0));
    check("rst_rvalid", 64'(rvo[u]), 64'(0));
    check("rst_rdata", 64'(rdata[u]), 64'(0));
    check("rst_err", 64'(err[u]), 64'(0));
    check("rst_valids", 64'({awvalid[u], wvalid[u], arvalid[u]}), 64'(0));
    check("rst_readies", 64'({bready[u], rready[u]}), 64'(0));
  endtask

  // One IDLE cycle: checks any due response, predicts the winner, captures the granted request.
  task automatic idle_cycle(input int u, output bit granted, output int win);
    slave_idle(u);
    settle();
    if (resp_due[u]) begin
      check("resp_rvalid", 64'(rvo[u]), 64'(resp_own[u] == 0 ? 2'b01 : 2'b10));
      check("resp_err", 64'(err[u]), 64'(resp_err[u]));
      if (resp_data[u]) check("resp_rdata", 64'(rdata[u]), 64'(exp_rdata[u]));
      resp_due[u] = 0;
    end else begin
      check("idle_rvalid", 64'(rvo[u]), 64'(0));
    end
    check("idle_valids", 64'({awvalid[u], wvalid[u], arvalid[u]}), 64'(0));
    case (req[u])
      2'b11:   win = 1 - last_win[u];
      2'b01:   win = 0;
      2'b10:   win = 1;
      default: win = -1;
    endcase
    obs_gnt = gnt[u];
    check("gnt", 64'(gnt[u]), (win < 0) ? 64'(0) : (64'(1) << win));
    granted = (win >= 0);
    if (granted) begin
      last_win[u] = win;
      c_we    = we[u][win];
      c_addr  = addr[u][win];
      c_wdata = wdata[u][win];
      c_be    = be[u][win];
    end
    cyc();
  endtask

  // Plays the AXI slave for the granted transaction; d_a/d_w/d_r are ready/response delays.
  task automatic serve(input int u, input int win, input int d_a, input int d_w, input int d_r,
                       input logic [31:0] rdat, input logic [1:0] resp, input bit rearm);
    bit aw_done, w_done;
    int k;
    if (!rearm) req[u][win] = 1'b0;
    resp_own[u] = win;
    if (!legal(u, c_addr)) begin
      settle();
      check("lerr_no_axi", 64'({awvalid[u], wvalid[u], arvalid[u]}), 64'(0));
      check("lerr_gnt", 64'(gnt[u]), 64'(0));
      resp_due[u] = 1; resp_err[u] = 1; resp_data[u] = 0;
      cyc();
    end else if (!c_we) begin
      for (int i = 0; i <= d_a; i++) begin
        arready[u] = (i == d_a);
        settle();
        check("ar_valid", 64'(arvalid[u]), 64'(1));
        check("ar_addr", 64'(araddr[u]), 64'(c_addr));
        check("ar_const", 64'({arid[u], arlen[u], arsize[u], arburst[u]}), 64'({4'h0, 8'd0, 3'd2, 2'b01}));
        check("busy_gnt", 64'(gnt[u]), 64'(0));
        cyc();
      end
      arready[u] = 0;
      for (int i = 0; i <= d_r; i++) begin
        rvalid[u] = (i == d_r);
        rd[u]     = (i == d_r) ? rdat : $urandom;
        rresp[u]  = resp;
        settle();
        check("r_ready", 64'({rready[u], arvalid[u]}), 64'(2'b10));
        check("busy_gnt", 64'(gnt[u]), 64'(0));
        cyc();
      end
      rvalid[u] = 0;
      resp_due[u] = 1; resp_err[u] = resp[1]; resp_data[u] = 1; exp_rdata[u] = rdat;
    end else begin
      aw_done = 0; w_done = 0; k = 0;
      while (!(aw_done && w_done)) begin
        awready[u] = (k >= d_a);
        wready[u]  = (k >= d_w);
        settle();
        check("aw_valid", 64'(awvalid[u]), 64'(!aw_done));
        check("w_valid", 64'(wvalid[u]), 64'(!w_done));
        if (!aw_done) begin
          check("aw_addr", 64'(awaddr[u]), 64'(c_addr));
          check("aw_const", 64'({awid[u], awlen[u], awsize[u], awburst[u]}), 64'({4'h0, 8'd0, 3'd2, 2'b01}));
        end
        if (!w_done) begin
          check("w_data", 64'({wd[u], wstrb[u], wlast[u]}), 64'({c_wdata, c_be, 1'b1}));
        end
        check("busy_gnt", 64'(gnt[u]), 64'(0));
        if (awready[u]) aw_done = 1;
        if (wready[u]) w_done = 1;
        k++;
        cyc();
      end
      awready[u] = 0; wready[u] = 0;
      for (int i = 0; i <= d_r; i++) begin
        bvalid[u] = (i == d_r);
        bresp[u]  = resp;
        settle();
        check("b_ready", 64'({bready[u], awvalid[u], wvalid[u]}), 64'(3'b100));
        check("busy_gnt", 64'(gnt[u]), 64'(0));
        cyc();
      end
      bvalid[u] = 0;
      resp_due[u] = 1; resp_err[u] = resp[1]; resp_data[u] = 1;
    end
  endtask

  task automatic new_req(input int u, input int p);
    logic [31:0] a;
    if (u == 0) a = $urandom;
    else        a = 32'h8000_0000 + 32'($urandom_range(0, 32'h1010)) - 32'd8;
    req[u][p]   = 1'b1;
    we[u][p]    = 1'($urandom);
    addr[u][p]  = a & 32'hFFFF_FFFC;
    wdata[u][p] = $urandom;
    be[u][p]    = 4'($urandom);
  endtask

  task automatic drain(input int u);
    bit g;
    int w;
    while (req[u] != 0 || resp_due[u]) begin
      idle_cycle(u, g, w);
      if (g) serve(u, w, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom, 2'($urandom), 0);
    end
  endtask

  initial begin
    bit g;
    int w;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      req[u] = '0; we[u] = '0; addr[u] = '0; wdata[u] = '0; be[u] = '0;
      slave_idle(u);
    end
    model_reset();
    repeat (2) cyc();
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    cyc();

    // Contention: both ports read continuously, slave always ready.
    req[0] = 2'b11; we[0] = 2'b00;
    addr[0][0] = 32'h0000_1000; addr[0][1] = 32'h0000_2000;
    for (int i = 0; i < 4; i++) begin
      idle_cycle(0, g, w);
      check("contend_gnt", 64'(obs_gnt), 64'((i % 2) ? 2'b10 : 2'b01));
      serve(0, w, 0, 0, 0, 32'hC0DE_0000 + 32'(i), 2'b00, 1);
    end
    req[0] = 2'b00;
    drain(0);

    // Single read, port 0, arready after 2 cycles.
    req[0] = 2'b01; we[0] = 2'b00; addr[0][0] = 32'h0000_0100;
    idle_cycle(0, g, w);
    check("rd_gnt", 64'(obs_gnt), 64'(2'b01));
    serve(0, w, 2, 0, 1, 32'hDEAD_BEEF, 2'b00, 0);
    drain(0);

    // Write with skew: W accepted 3 cycles before AW, SLVERR response.
    req[0] = 2'b10; we[0] = 2'b10; addr[0][1] = 32'h0000_0200;
    wdata[0][1] = 32'h0000_55AA; be[0][1] = 4'b0011;
    idle_cycle(0, g, w);
    check("wr_gnt", 64'(obs_gnt), 64'(2'b10));
    serve(0, w, 3, 0, 1, 32'h0, 2'b10, 0);
    drain(0);

    // Window instance: just past the top, last legal word, below base, write at base.
    req[1] = 2'b10; we[1] = 2'b00; addr[1][1] = 32'h8000_1000;
    idle_cycle(1, g, w);
    serve(1, w, 0, 0, 0, 32'h0, 2'b00, 0);
    drain(1);
    req[1] = 2'b01; we[1] = 2'b00; addr[1][0] = 32'h8000_0FFC;
    idle_cycle(1, g, w);
    serve(1, w, 1, 0, 0, 32'h1234_5678, 2'b00, 0);
    drain(1);
    req[1] = 2'b01; we[1] = 2'b00; addr[1][0] = 32'h7FFF_FFFC;
    idle_cycle(1, g, w);
    serve(1, w, 0, 0, 0, 32'h0, 2'b00, 0);
    drain(1);
    req[1] = 2'b10; we[1] = 2'b10; addr[1][1] = 32'h8000_0000;
    wdata[1][1] = 32'hA5A5_0F0F; be[1][1] = 4'b1111;
    idle_cycle(1, g, w);
    serve(1, w, 0, 2, 0, 32'h0, 2'b00, 0);
    drain(1);

    // Randomized traffic on both instances.
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 250; n++) begin
        for (int p = 0; p < 2; p++) begin
          if (!req[u][p] && $urandom_range(0, 2) != 0) new_req(u, p);
        end
        idle_cycle(u, g, w);
        if (g) serve(u, w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom, 2'($urandom), 0);
      end
      drain(u);
    end

    // Asynchronous reset while in R.
    req[0] = 2'b01; we[0] = 2'b00; addr[0][0] = 32'h0000_0300;
    idle_cycle(0, g, w);
    req[0] = 2'b00;
    arready[0] = 1;
    settle();
    check("arst_pre_ar", 64'(arvalid[0]), 64'(1));
    cyc();
    arready[0] = 0;
    settle();
    check("arst_pre_r", 64'(rready[0]), 64'(1));
    rst_n = 1'b0;
    #1;
    check_reset_outputs(0);
    model_reset();
    cyc();
    rst_n = 1'b1;
    cyc();

    // After release, contention again starts with port 0.
    req[0] = 2'b11; we[0] = 2'b00; addr[0][0] = 32'h0000_0400; addr[0][1] = 32'h0000_0500;
    idle_cycle(0, g, w);
    check("post_rst_gnt", 64'(obs_gnt), 64'(2'b01));
    serve(0, w, 1, 0, 0, 32'hFEED_F00D, 2'b00, 0);
    drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
